// File: rtl/alu_vec_pkg.sv
// Shared types for the vector ALU: opcodes, FSM states and the div/rem opcode test.
package alu_vec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_DIV = 3'b101,
    OP_REM = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [2:0] OP_DIV_CODE = 3'b101;
  localparam logic [2:0] OP_REM_CODE = 3'b110;

  function automatic logic is_divrem(input logic [2:0] op);
    return (op == OP_DIV_CODE) || (op == OP_REM_CODE);
  endfunction

endpackage

// File: rtl/alu_lane_div.sv
// One-lane restoring divider: loads magnitudes on start, retires one quotient bit per step.
module alu_lane_div #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               start_i,
  input  logic               step_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] quot_o,
  output logic [2*WIDTH-1:0] rem_o,
  output logic               dz_o
);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             qneg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_sh, trial;
  logic [WIDTH-1:0] quo_step, rem_step;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  always_comb begin
    a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  always_comb begin
    r_sh  = {rem_q, quo_q[WIDTH-1]};
    trial = r_sh - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = r_sh[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (start_i) begin
      quo_q  <= a_mag;
      rem_q  <= '0;
      dvs_q  <= b_mag;
      qneg_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_q <= signed_i & a_i[WIDTH-1];
      dz_q   <= (b_i == '0);
    end else if (step_i) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
    end
  end

  // Outputs reflect the step in progress so the last step's result is usable on its own edge.
  always_comb begin
    quot_o = qneg_q ? -{{WIDTH{1'b0}}, quo_step} : {{WIDTH{1'b0}}, quo_step};
    rem_o  = rneg_q ? -{{WIDTH{1'b0}}, rem_step} : {{WIDTH{1'b0}}, rem_step};
    dz_o   = dz_q;
  end

endmodule

// File: rtl/alu_vec_pipe.sv
// N-lane vector ALU with a shared valid/ready handshake and per-lane iterative dividers.
module alu_vec_pipe
  import alu_vec_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N*WIDTH-1:0]     a_i,
  input  logic [N*WIDTH-1:0]     b_i,
  input  logic [N*3-1:0]         op_i,
  input  logic [N-1:0]           lane_en_i,
  input  logic                   op_signed_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N*2*WIDTH-1:0]   z_o,
  output logic [N-1:0]           dz_o
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                load_res;
  logic                accept;
  logic [N-1:0]        div_req;

  logic [N*WIDTH-1:0]  a_q, b_q;
  logic [N*3-1:0]      op_q;
  logic [N-1:0]        en_q;
  logic                sgn_q;

  logic [N*W2-1:0]     lane_z;
  logic [N-1:0]        lane_dz;
  logic [N*W2-1:0]     z_q;
  logic [N-1:0]        dz_q;

  assign accept = in_valid_i && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_res = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid_i) state_d = (|div_req) ? DIV : CALC;
      end
      CALC: begin
        load_res = 1'b1;
        state_d  = HOLD;
      end
      DIV: begin
        if (cnt_q == CNT_LAST) begin
          load_res = 1'b1;
          state_d  = HOLD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      en_q    <= '0;
      sgn_q   <= 1'b0;
      z_q     <= '0;
      dz_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        op_q  <= op_i;
        en_q  <= lane_en_i;
        sgn_q <= op_signed_i;
      end
      if (load_res) begin
        z_q  <= lane_z;
        dz_q <= lane_dz;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [WIDTH-1:0] a_l, b_l;
      logic [2:0]       op_l;
      logic [W2-1:0]    ea, eb, res, quot, rem;
      logic             div_dz, res_dz;

      assign div_req[gi] = lane_en_i[gi] & is_divrem(op_i[gi*3 +: 3]);
      assign a_l  = a_q[gi*WIDTH +: WIDTH];
      assign b_l  = b_q[gi*WIDTH +: WIDTH];
      assign op_l = op_q[gi*3 +: 3];

      // The divider loads straight from the inputs so all WIDTH DIV cycles are steps.
      alu_lane_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .arst     (arst),
        .start_i  (accept),
        .step_i   (state_q == DIV),
        .signed_i (op_signed_i),
        .a_i      (a_i[gi*WIDTH +: WIDTH]),
        .b_i      (b_i[gi*WIDTH +: WIDTH]),
        .quot_o   (quot),
        .rem_o    (rem),
        .dz_o     (div_dz)
      );

      always_comb begin
        ea     = sgn_q ? {{WIDTH{a_l[WIDTH-1]}}, a_l} : {{WIDTH{1'b0}}, a_l};
        eb     = sgn_q ? {{WIDTH{b_l[WIDTH-1]}}, b_l} : {{WIDTH{1'b0}}, b_l};
        res    = '0;
        res_dz = 1'b0;
        case (op_e'(op_l))
          OP_ADD: res = ea + eb;
          OP_SUB: res = ea - eb;
          OP_AND: res = ea & eb;
          OP_OR:  res = ea | eb;
          OP_MUL: res = ea * eb;
          OP_DIV: res = quot;
          OP_REM: res = rem;
          OP_XOR: res = ea ^ eb;
          default: res = '0;
        endcase
        if (is_divrem(op_l) && div_dz) begin
          res    = '0;
          res_dz = 1'b1;
        end
        if (!en_q[gi]) begin
          res    = '0;
          res_dz = 1'b0;
        end
      end

      assign lane_z[gi*W2 +: W2] = res;
      assign lane_dz[gi]         = res_dz;
    end
  endgenerate

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == HOLD);
  assign z_o         = z_q;
  assign dz_o        = dz_q;

endmodule
